lighthouse_multi_decoder: RTL and testbench

Parametrised multi-sensor lighthouse pulse decoder for the darkroom tracking subsystem. It timestamps the envelope outputs of NUM_SENSORS TS4231 front-ends against one free-running timer. Each envelope pulse is classified as a sync or a sweep pulse, and sweep pulses are converted into a sweep time relative to that channel's last sync. The resulting events are merged by a round-robin arbiter into one FIFO-backed valid/ready stream for the host-side bridge. This block replaces the fixed two-channel sensor logic and works alongside the existing SPI configuration path, which is not part of this block.

---
 rtl/lighthouse_multi_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_lighthouse_multi_decoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lighthouse_multi_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lighthouse_multi_decoder
// Description : Multi-channel lighthouse envelope decoder. Timestamps, classifies
//               and merges sync/sweep events into one FIFO-backed stream.
// Revision    : 1.0 - initial release
// ============================================================================
module lighthouse_multi_decoder #(
    parameter int NUM_SENSORS     = 4,
    parameter int TIMER_W         = 24,
    parameter int WIDTH_W         = 13,
    parameter int SYNC_MIN_TICKS  = 2500,
    parameter int MIN_PULSE_TICKS = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int ID_W            = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_SENSORS-1:0]               envelope_i,
    output logic [ID_W+1+WIDTH_W+TIMER_W-1:0]    m_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [NUM_SENSORS-1:0]               overflow_o,
    input  logic                                 clear_overflow_i,
    output logic [TIMER_W-1:0]                   timer_o
);

    localparam int EVT_W  = 1 + WIDTH_W + TIMER_W;
    localparam int WORD_W = ID_W + EVT_W;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    localparam logic [WIDTH_W-1:0]  c_width_max = '1;
    localparam logic [WIDTH_W-1:0]  c_sync_min  = WIDTH_W'(SYNC_MIN_TICKS);
    localparam logic [WIDTH_W-1:0]  c_min_pulse = WIDTH_W'(MIN_PULSE_TICKS);
    localparam logic [ADDR_W+1:0]   c_depth     = (ADDR_W+2)'(FIFO_DEPTH);

    logic [TIMER_W-1:0]     r_timer;
    logic [NUM_SENSORS-1:0] r_sync1, r_sync2, r_sync3, r_armed;
    logic [NUM_SENSORS-1:0] w_rise, w_fall;

    logic [TIMER_W-1:0]     r_rise_ts [NUM_SENSORS];
    logic [TIMER_W-1:0]     r_sync_ts [NUM_SENSORS];
    logic [WIDTH_W-1:0]     r_width   [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_has_sync;
    logic [NUM_SENSORS-1:0] r_evt_valid;
    logic [EVT_W-1:0]       r_evt_data  [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_pend_valid;
    logic [EVT_W-1:0]       r_pend_data [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] r_overflow;

    logic [ID_W-1:0]        r_ptr;
    logic                   w_can_grant, w_grant_any;
    logic [ID_W-1:0]        w_grant_idx;
    logic [NUM_SENSORS-1:0] w_grant_oh;
    logic                   r_push_valid;
    logic [WORD_W-1:0]      r_push_word;

    logic [WORD_W-1:0]      r_mem [FIFO_DEPTH];
    logic [ADDR_W:0]        r_wptr, r_rptr;
    logic [ADDR_W:0]        w_count;
    logic                   w_empty, w_pop;
    logic [ADDR_W+1:0]      w_occ_next;

    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] ptr, input int step);
        int j;
        j = int'(ptr) + step;
        if (j >= NUM_SENSORS) j = j - NUM_SENSORS;
        return ID_W'(j);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
            r_armed <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
            r_sync1 <= envelope_i;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_armed <= r_armed | ~r_sync2;
        end
    end

    // Edges only count once the line has been seen low, so a pulse already in
    // progress at reset release is ignored entirely.
    assign w_rise = r_sync2 & ~r_sync3 & r_armed;
    assign w_fall = ~r_sync2 & r_sync3 & r_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_has_sync  <= '0;
            r_evt_valid <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_rise_ts[i] <= '0;
                r_sync_ts[i] <= '0;
                r_width[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                r_evt_valid[i] <= 1'b0;
                if (w_rise[i]) begin
                    r_rise_ts[i] <= r_timer;
                    r_width[i]   <= WIDTH_W'(1);
                end else if (r_sync2[i] && (r_width[i] != c_width_max)) begin
                    r_width[i] <= r_width[i] + 1'b1;
                end
                if (w_fall[i] && (r_width[i] >= c_min_pulse)) begin
                    if (r_width[i] >= c_sync_min) begin
                        r_sync_ts[i]   <= r_rise_ts[i];
                        r_has_sync[i]  <= 1'b1;
                        r_evt_valid[i] <= 1'b1;
                        r_evt_data[i]  <= {1'b1, r_width[i], r_rise_ts[i]};
                    end else if (r_has_sync[i]) begin
                        r_evt_valid[i] <= 1'b1;
                        r_evt_data[i]  <= {1'b0, r_width[i], r_rise_ts[i] - r_sync_ts[i]};
                    end
                end
            end
        end
    end

    // Occupancy the FIFO will have after this edge; a grant made now lands one
    // cycle later, so it must fit behind everything already in flight.
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == '0);
    assign w_pop       = !w_empty && m_ready;
    assign w_occ_next  = {1'b0, w_count} + (ADDR_W+2)'(r_push_valid) - (ADDR_W+2)'(w_pop);
    assign w_can_grant = (w_occ_next < c_depth);

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        if (w_can_grant) begin
            for (int k = NUM_SENSORS - 1; k >= 0; k--) begin
                if (r_pend_valid[rr_index(r_ptr, k)]) begin
                    w_grant_any = 1'b1;
                    w_grant_idx = rr_index(r_ptr, k);
                end
            end
        end
    end

    always_comb begin
        w_grant_oh = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            w_grant_oh[i] = w_grant_any && (w_grant_idx == ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= '0;
            r_overflow   <= '0;
            r_ptr        <= '0;
            r_push_valid <= 1'b0;
        end else begin
            r_push_valid <= w_grant_any;
            if (w_grant_any) begin
                r_push_word <= {w_grant_idx, r_pend_data[w_grant_idx]};
                r_ptr       <= rr_index(w_grant_idx, 1);
            end
            if (clear_overflow_i) r_overflow <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (w_grant_oh[i]) r_pend_valid[i] <= 1'b0;
                if (r_evt_valid[i]) begin
                    if (!r_pend_valid[i] || w_grant_oh[i]) begin
                        r_pend_valid[i] <= 1'b1;
                        r_pend_data[i]  <= r_evt_data[i];
                    end else begin
                        r_overflow[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (r_push_valid) r_wptr <= r_wptr + 1'b1;
            if (w_pop)        r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_push_valid) r_mem[r_wptr[ADDR_W-1:0]] <= r_push_word;
    end

    assign m_valid    = !w_empty;
    assign m_data     = w_empty ? '0 : r_mem[r_rptr[ADDR_W-1:0]];
    assign overflow_o = r_overflow;
    assign timer_o    = r_timer;

endmodule
`default_nettype wire

// File: tb/tb_lighthouse_multi_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lighthouse_multi_decoder
// Description : Randomised self-checking bench with a pulse-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lighthouse_multi_decoder;

    localparam int NS     = 4;
    localparam int TW     = 14;
    localparam int WW     = 13;
    localparam int IDW    = 2;
    localparam int WORD_W = IDW + 1 + WW + TW;
    localparam int TMASK  = (1 << TW) - 1;
    localparam int WMAX   = (1 << WW) - 1;
    // Timer ticks from the cycle a pin change is driven to its rise_ts capture.
    localparam int EDGE_LAT = 2;

    logic              clk, reset, m_valid, m_ready, clear_overflow_i;
    logic [NS-1:0]     envelope_i, overflow_o;
    logic [WORD_W-1:0] m_data;
    logic [TW-1:0]     timer_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WORD_W-1:0] got_q[$];
    int                got_t[$];
    logic [WORD_W-1:0] exp_q[$];
    bit                m_has_sync[NS];
    int                m_sync_ts[NS];

    lighthouse_multi_decoder #(
        .NUM_SENSORS(NS), .TIMER_W(TW), .WIDTH_W(WW), .SYNC_MIN_TICKS(2500),
        .MIN_PULSE_TICKS(4), .FIFO_DEPTH(16)
    ) u_dut (
        .clk(clk), .reset(reset), .envelope_i(envelope_i), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .overflow_o(overflow_o),
        .clear_overflow_i(clear_overflow_i), .timer_o(timer_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            got_t.push_back(cyc);
        end
    end

    function automatic logic [WORD_W-1:0] mk(input int ch, input bit s, input int w, input int v);
        logic [IDW-1:0] id;
        logic [WW-1:0]  wf;
        logic [TW-1:0]  vv;
        id = ch[IDW-1:0];
        wf = w[WW-1:0];
        vv = v[TW-1:0];
        return {id, s, wf, vv};
    endfunction

    task automatic model_pulse(input int ch, input int rise, input int w);
        int wf;
        wf = (w > WMAX) ? WMAX : w;
        if (w < 4) return;
        if (w >= 2500) begin
            m_sync_ts[ch]  = rise;
            m_has_sync[ch] = 1'b1;
            exp_q.push_back(mk(ch, 1'b1, wf, rise));
        end else if (m_has_sync[ch]) begin
            exp_q.push_back(mk(ch, 1'b0, wf, (rise - m_sync_ts[ch]) & TMASK));
        end
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [NS-1:0] mask, input int w, output int rise);
        envelope_i = envelope_i | mask;
        rise = (int'(timer_o) + EDGE_LAT) & TMASK;
        idle(w);
        envelope_i = envelope_i & ~mask;
    endtask

    task automatic do_reset();
        envelope_i = '0;
        m_ready = 1'b1;
        clear_overflow_i = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        for (int c = 0; c < NS; c++) begin
            m_has_sync[c] = 1'b0;
            m_sync_ts[c]  = 0;
        end
    endtask

    task automatic wait_words(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
    endtask

    task automatic test_reset();
        envelope_i = 4'b0001;
        m_ready = 1'b1;
        clear_overflow_i = 1'b0;
        reset = 1'b1;
        idle(3);
        checks++; if (timer_o !== '0) begin errors++; $display("FAIL reset_timer got %0h want 0", timer_o); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", m_data); end
        checks++; if (overflow_o !== '0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow_o); end
        reset = 1'b0;
        got_q.delete();
        idle(5);
        checks++; if (timer_o !== TW'(5)) begin errors++; $display("FAIL timer_count got %0d want 5", timer_o); end
        idle(20);
        envelope_i = '0;
        idle(30);
        checks++; if (got_q.size() != 0 || m_valid !== 1'b0) begin
            errors++; $display("FAIL reset_high_no_event got %0d words valid=%0b want 0", got_q.size(), m_valid);
        end
        checks++; if (overflow_o !== '0) begin errors++; $display("FAIL reset_high_overflow got %0b want 0", overflow_o); end
    endtask

    task automatic test_sync_sweep();
        int r, w;
        bit ok;
        logic [WORD_W-1:0] wd;
        do_reset();
        pulse(4'b0100, 3000, r); model_pulse(2, r, 3000);
        idle(1000);
        pulse(4'b0100, 50, r);   model_pulse(2, r, 50);
        for (int n = 0; n < 5; n++) begin
            idle($urandom_range(5, 200));
            w = $urandom_range(1, 2499);
            pulse(4'b0100, w, r); model_pulse(2, r, w);
        end
        wait_words(exp_q.size(), 200, ok);
        checks++; if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL sync_sweep_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL sync_sweep_word[%0d] got %0h want %0h", k, got_q[k], exp_q[k]);
            end
        end
        wd = (got_q.size() > 1) ? got_q[1] : '0;
        checks++; if (wd !== mk(2, 1'b0, 50, 4000)) begin
            errors++; $display("FAIL sweep_4000 got %0h want %0h", wd, mk(2, 1'b0, 50, 4000));
        end
    endtask

    task automatic test_boundaries();
        int r;
        bit ok;
        int widths[7] = '{3, 2499, 2500, 9000, 4, 3, 2499};
        logic [WORD_W-1:0] wd;
        do_reset();
        foreach (widths[n]) begin
            pulse(4'b0001, widths[n], r); model_pulse(0, r, widths[n]);
            idle(20);
        end
        wait_words(exp_q.size(), 100, ok);
        checks++; if (!ok || got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL boundary_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL boundary_word[%0d] got %0h want %0h", k, got_q[k], exp_q[k]);
            end
        end
        wd = (got_q.size() > 1) ? got_q[1] : '0;
        checks++; if (wd[TW+WW-1:TW] !== WW'(WMAX) || wd[TW+WW] !== 1'b1) begin
            errors++; $display("FAIL width_saturate got w=%0d s=%0b want w=%0d s=1", wd[TW+WW-1:TW], wd[TW+WW], WMAX);
        end
    endtask

    task automatic test_timer_wrap();
        int r;
        bit ok;
        logic [WORD_W-1:0] wd;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (timer_o == TW'(16'h3F00 - EDGE_LAT)) begin ok = 1'b1; break; end
            idle(1);
        end
        checks++; if (!ok) begin errors++; $display("FAIL wrap_timer_reach got %0h want %0h", timer_o, 16'h3F00 - EDGE_LAT); end
        pulse(4'b1000, 2600, r); model_pulse(3, r, 2600);
        idle(4096 - 2600);
        pulse(4'b1000, 100, r);  model_pulse(3, r, 100);
        wait_words(2, 100, ok);
        for (int k = 0; k < 2; k++) begin
            wd = (got_q.size() > k) ? got_q[k] : '0;
            checks++; if (wd !== exp_q[k]) begin
                errors++; $display("FAIL wrap_word[%0d] got %0h want %0h", k, wd, exp_q[k]);
            end
        end
        wd = (got_q.size() > 1) ? got_q[1] : '0;
        checks++; if (wd[TW-1:0] !== TW'(16'h1000)) begin
            errors++; $display("FAIL wrap_value got %0h want 1000", wd[TW-1:0]);
        end
    endtask

    task automatic test_contention();
        int r, w;
        bit ok;
        do_reset();
        pulse(4'b1111, 2600, r);
        for (int c = 0; c < NS; c++) model_pulse(c, r, 2600);
        idle(400);
        w = $urandom_range(4, 2499);
        pulse(4'b1111, w, r);
        for (int c = 0; c < NS; c++) model_pulse(c, r, w);
        wait_words(8, 100, ok);
        checks++; if (!ok || got_q.size() != 8) begin
            errors++; $display("FAIL contention_count got %0d want 8", got_q.size());
        end
        for (int k = 0; k < 8 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL contention_word[%0d] got %0h want %0h", k, got_q[k], exp_q[k]);
            end
            if (k % 4 != 0) begin
                checks++; if (got_t[k] - got_t[k-1] != 1) begin
                    errors++; $display("FAIL contention_gap[%0d] got %0d want 1", k, got_t[k] - got_t[k-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int r, w;
        bit ok;
        logic [WORD_W-1:0] held;
        do_reset();
        m_ready = 1'b0;
        pulse(4'b0010, 2600, r); model_pulse(1, r, 2600);
        for (int n = 0; n < 16; n++) begin
            idle($urandom_range(3, 12));
            w = $urandom_range(4, 60);
            pulse(4'b0010, w, r); model_pulse(1, r, w);
        end
        idle(20);
        checks++; if (overflow_o !== '0) begin errors++; $display("FAIL ovf_after17 got %0b want 0", overflow_o); end
        checks++; if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin
            errors++; $display("FAIL stall_head got v=%0b d=%0h want v=1 d=%0h", m_valid, m_data, exp_q[0]);
        end
        held = m_data;
        idle(5);
        pulse(4'b0010, 10, r);
        idle(20);
        checks++; if (overflow_o !== 4'b0010) begin errors++; $display("FAIL ovf_set got %0b want 0010", overflow_o); end
        checks++; if (m_data !== held) begin errors++; $display("FAIL stall_stable got %0h want %0h", m_data, held); end
        clear_overflow_i = 1'b1;
        idle(1);
        clear_overflow_i = 1'b0;
        checks++; if (overflow_o !== '0) begin errors++; $display("FAIL ovf_clear got %0b want 0", overflow_o); end
        m_ready = 1'b1;
        wait_words(17, 100, ok);
        idle(20);
        checks++; if (!ok || got_q.size() != 17) begin
            errors++; $display("FAIL drain_count got %0d want 17", got_q.size());
        end
        for (int k = 0; k < 17 && k < got_q.size(); k++) begin
            checks++; if (got_q[k] !== exp_q[k]) begin
                errors++; $display("FAIL drain_word[%0d] got %0h want %0h", k, got_q[k], exp_q[k]);
            end
        end
        checks++; if (got_q.size() >= 17 && got_t[16] - got_t[0] != 16) begin
            errors++; $display("FAIL drain_rate got %0d cycles want 16", got_t[16] - got_t[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        envelope_i = '0;
        m_ready = 1'b1;
        clear_overflow_i = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_sync_sweep();
        test_boundaries();
        test_timer_wrap();
        test_contention();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
